lcd_timebase: RTL

//  Timebase and delay service fed by the MSS CCC fabric clock output (GLA0, RC oscillator).
//  - Free-running 1 us and 1 ms clock-enable ticks.
//  - Power-on wait flag that holds off the LCD controller until the panel supply has settled.
//  - Single-channel microsecond delay timer with a start/busy/done handshake.

---
 rtl/lcd_timebase.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/lcd_timebase.sv
// Microsecond/millisecond timebase, power-on settle flag and one-channel
// microsecond delay timer for the LCD command sequencer.
module lcd_timebase #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int POR_MS      = 40,
  parameter int DLY_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  output logic             US_TICK,
  output logic             MS_TICK,
  output logic             POR_DONE,
  input  logic             DLY_START,
  input  logic [DLY_W-1:0] DLY_US,
  output logic             DLY_BUSY,
  output logic             DLY_DONE,
  output logic [2:0]       dbg_state
);

  localparam int DIV   = CLK_FREQ_HZ / 1000000;
  localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [9:0]       MS_MAX   = 10'd999;
  localparam logic [9:0]       CNT_ONE  = 10'd1;
  localparam logic [9:0]       POR_LAST = 10'(POR_MS - 1);
  localparam logic [DLY_W-1:0] REM_ONE  = DLY_W'(1);

  if ((CLK_FREQ_HZ % 1000000) != 0 || DIV < 2) begin : g_bad_clk
    $error("lcd_timebase: CLK_FREQ_HZ/1000000 must be an integer >= 2");
  end
  if (POR_MS < 1 || POR_MS > 1023) begin : g_bad_por
    $error("lcd_timebase: POR_MS must lie in 1..1023");
  end

  typedef enum logic {
    POR_WAIT  = 1'b0,
    POR_READY = 1'b1
  } por_state_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } dly_state_t;

  logic [PRE_W-1:0] pre;
  logic [9:0]       ms_cnt;
  logic [9:0]       por_cnt;
  logic [DLY_W-1:0] rem;
  por_state_t       por_state;
  dly_state_t       dly_state;
  logic             accept;

  assign dbg_state = {por_state, dly_state};

  // US_TICK and MS_TICK are decided from the same registered prescaler
  // terminal count so the millisecond pulse lands exactly on a microsecond one.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pre     <= '0;
      ms_cnt  <= '0;
      US_TICK <= 1'b0;
      MS_TICK <= 1'b0;
    end else begin
      US_TICK <= (pre == PRE_MAX);
      MS_TICK <= 1'b0;
      if (pre == PRE_MAX) begin
        pre     <= '0;
        MS_TICK <= (ms_cnt == MS_MAX);
        ms_cnt  <= (ms_cnt == MS_MAX) ? '0 : ms_cnt + CNT_ONE;
      end else begin
        pre <= pre + PRE_ONE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      por_state <= POR_WAIT;
      por_cnt   <= '0;
      POR_DONE  <= 1'b0;
    end else begin
      unique case (por_state)
        POR_WAIT: begin
          if (MS_TICK) begin
            if (por_cnt == POR_LAST) begin
              por_state <= POR_READY;
              POR_DONE  <= 1'b1;
            end else begin
              por_cnt <= por_cnt + CNT_ONE;
            end
          end
        end
        POR_READY: POR_DONE <= 1'b1;
        default: begin
          por_state <= POR_WAIT;
          POR_DONE  <= 1'b0;
        end
      endcase
    end
  end

  // Handshake: a request is taken only when DLY_START=1, POR_DONE=1 and the
  // timer is idle (DLY_BUSY=0); anything else is dropped, never queued.
  // DLY_BUSY rises the cycle after acceptance and drops together with the
  // single-cycle DLY_DONE pulse; the next request can be taken one cycle later.
  assign accept = DLY_START & POR_DONE & (dly_state == S_IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      dly_state <= S_IDLE;
      rem       <= '0;
      DLY_BUSY  <= 1'b0;
      DLY_DONE  <= 1'b0;
    end else begin
      DLY_DONE <= 1'b0;
      unique case (dly_state)
        S_IDLE: begin
          if (accept) begin
            rem      <= DLY_US;
            DLY_BUSY <= 1'b1;
            if (DLY_US == '0) begin
              dly_state <= S_DONE;
              DLY_DONE  <= 1'b1;
            end else begin
              dly_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (US_TICK) begin
            rem <= rem - REM_ONE;
            if (rem == REM_ONE) begin
              dly_state <= S_DONE;
              DLY_DONE  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          dly_state <= S_IDLE;
          DLY_BUSY  <= 1'b0;
        end
        default: begin
          dly_state <= S_IDLE;
          DLY_BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
